// File: rtl/ps2_cmd_queue.sv
// Turns held-button vectors from two PS/2 pads into press/auto-repeat events,
// merged round-robin into one FIFO read through a valid/ready handshake.
module ps2_cmd_queue #(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 5000000,
    parameter logic [9:0]  REPEAT_MASK  = 10'b0011110000,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [9:0]                    c1,
    input  logic [9:0]                    c2,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic                          evt_player,
    output logic [3:0]                    evt_code,
    output logic                          evt_repeat,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          overflow,
    output logic [3:0]                    dbg_state
);

    localparam int unsigned TMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TW = $clog2(TMAX + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TW-1:0] T_DELAY = TW'(REPEAT_DELAY);
    localparam logic [TW-1:0] T_RATE  = TW'(REPEAT_RATE);
    localparam logic [TW-1:0] T_ONE   = TW'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, REPEAT = 2'd2} state_e;

    // Exactly one bit set yields index+1; anything else reads as released.
    function automatic logic [3:0] decode(input logic [9:0] v);
        logic [3:0] r;
        r = 4'd0;
        if ($onehot(v)) begin
            for (int i = 0; i < 10; i++) begin
                if (v[i]) r = 4'(i + 1);
            end
        end
        return r;
    endfunction

    logic [9:0]    c1_q, c2_q;
    logic [3:0]    code [2];
    state_e        state_q [2], state_d [2];
    logic [TW-1:0] timer_q [2], timer_d [2];
    logic [3:0]    held_q  [2], held_d  [2];
    logic          ev_v    [2];
    logic [5:0]    ev_e    [2];
    logic          pend_v_q [2], pend_v_d [2];
    logic [5:0]    pend_e_q [2], pend_e_d [2];
    logic          grant   [2];
    logic          rr_q, rr_d, ovf_q, ovf_d;
    logic          full, both, push, pop;
    logic [5:0]    push_e;
    logic [5:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;

    assign code[0] = decode(c1_q);
    assign code[1] = decode(c2_q);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            c1_q  <= '0;
            c2_q  <= '0;
            for (int p = 0; p < 2; p++) begin
                state_q[p]  <= IDLE;
                timer_q[p]  <= '0;
                held_q[p]   <= '0;
                pend_v_q[p] <= 1'b0;
                pend_e_q[p] <= '0;
            end
            rr_q  <= 1'b0;
            ovf_q <= 1'b0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            c1_q  <= c1;
            c2_q  <= c2;
            for (int p = 0; p < 2; p++) begin
                state_q[p]  <= state_d[p];
                timer_q[p]  <= timer_d[p];
                held_q[p]   <= held_d[p];
                pend_v_q[p] <= pend_v_d[p];
                pend_e_q[p] <= pend_e_d[p];
            end
            rr_q  <= rr_d;
            ovf_q <= ovf_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Per-player event FSM; event word is {player, code, repeat}.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            state_d[p] = state_q[p];
            timer_d[p] = timer_q[p];
            held_d[p]  = held_q[p];
            ev_v[p]    = 1'b0;
            ev_e[p]    = {1'(p), code[p], 1'b0};
            case (state_q[p])
                IDLE: begin
                    if (code[p] != 4'd0) begin
                        ev_v[p]    = 1'b1;
                        timer_d[p] = T_DELAY;
                        held_d[p]  = code[p];
                        state_d[p] = HELD;
                    end
                end
                HELD, REPEAT: begin
                    if (code[p] == 4'd0) begin
                        state_d[p] = IDLE;
                        held_d[p]  = 4'd0;
                    end else if (code[p] != held_q[p]) begin
                        ev_v[p]    = 1'b1;
                        timer_d[p] = T_DELAY;
                        held_d[p]  = code[p];
                        state_d[p] = HELD;
                    end else if (timer_q[p] == T_ONE) begin
                        // Non-repeatable codes park here with the timer saturated at 1.
                        if (state_q[p] == REPEAT || REPEAT_MASK[code[p] - 4'd1]) begin
                            ev_v[p]    = 1'b1;
                            ev_e[p][0] = 1'b1;
                            timer_d[p] = T_RATE;
                            state_d[p] = REPEAT;
                        end
                    end else begin
                        timer_d[p] = timer_q[p] - T_ONE;
                    end
                end
                default: state_d[p] = IDLE;
            endcase
        end
    end

    // Handshake: the head entry transfers on a cycle where evt_valid and evt_ready
    // are both high; evt_* stay stable while evt_valid is high and evt_ready is low.
    always_comb begin
        full     = (cnt_q == CW'(FIFO_DEPTH));
        both     = pend_v_q[0] & pend_v_q[1];
        grant[0] = !full && (both ? !rr_q : pend_v_q[0]);
        grant[1] = !full && (both ?  rr_q : pend_v_q[1]);
        push     = grant[0] | grant[1];
        push_e   = grant[1] ? pend_e_q[1] : pend_e_q[0];
        rr_d     = (push && both) ? ~rr_q : rr_q;
        pop      = (cnt_q != '0) && evt_ready;
        ovf_d    = ovf_q;
        // A slot being granted this cycle can take a new event at the same edge.
        for (int p = 0; p < 2; p++) begin
            pend_v_d[p] = pend_v_q[p] & ~grant[p];
            pend_e_d[p] = pend_e_q[p];
            if (ev_v[p]) begin
                if (pend_v_d[p]) begin
                    ovf_d = 1'b1;
                end else begin
                    pend_v_d[p] = 1'b1;
                    pend_e_d[p] = ev_e[p];
                end
            end
        end
        wr_d  = push ? wr_q + AW'(1) : wr_q;
        rd_d  = pop  ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_q] <= push_e;
    end

    assign evt_valid  = (cnt_q != '0);
    assign evt_player = evt_valid & mem[rd_q][5];
    assign evt_code   = evt_valid ? mem[rd_q][4:1] : 4'd0;
    assign evt_repeat = evt_valid & mem[rd_q][0];
    assign evt_count  = cnt_q;
    assign overflow   = ovf_q;
    assign dbg_state  = {state_q[1], state_q[0]};

endmodule

// File: tb/tb_ps2_cmd_queue.sv
// Bench for ps2_cmd_queue: directed scenarios then random pad activity, all
// compared every cycle against an event-level reference model.
module tb_ps2_cmd_queue;
    localparam int D     = 16;
    localparam int R     = 4;
    localparam int DEPTH = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] c1 = '0, c2 = '0;
    logic       evt_ready = 1'b0;
    logic       evt_valid, evt_player, evt_repeat, overflow;
    logic [3:0] evt_code, dbg_state;
    logic [2:0] evt_count;

    always #5 clock = ~clock;

    ps2_cmd_queue #(
        .REPEAT_DELAY(D), .REPEAT_RATE(R),
        .REPEAT_MASK(10'b0011110000), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock), .reset(reset), .c1(c1), .c2(c2),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_player(evt_player),
        .evt_code(evt_code), .evt_repeat(evt_repeat), .evt_count(evt_count),
        .overflow(overflow), .dbg_state(dbg_state)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: sampled vectors, held code, absolute cycle of next repeat,
    // pending slots, event queue.
    logic [9:0] m_s    [2];
    logic [3:0] m_held [2];
    int         m_next [2];
    logic       m_pv   [2];
    logic [5:0] m_pe   [2];
    logic [5:0] m_q    [$];
    logic       m_rr, m_ovf;
    int         cyc;
    logic [5:0] pop_log [$];

    function automatic logic [3:0] code_of(input logic [9:0] v);
        if ($countones(v) != 1) return 4'd0;
        for (int i = 0; i < 10; i++) if (v[i]) return 4'(i + 1);
        return 4'd0;
    endfunction

    function automatic logic [9:0] rand_vec();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return 10'd0;
        if (r < 9) return 10'd1 << $urandom_range(0, 9);
        return 10'($urandom);
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            m_s[p] = '0; m_held[p] = '0; m_next[p] = 0; m_pv[p] = 1'b0; m_pe[p] = '0;
        end
        m_q.delete();
        m_rr  = 1'b0;
        m_ovf = 1'b0;
        cyc   = 0;
    endtask

    task automatic model_edge(input logic [9:0] a, input logic [9:0] b, input logic rdy);
        int g;
        logic [3:0] cd;
        logic ev, rep;
        g = -1;
        if (m_q.size() < DEPTH) begin
            if (m_pv[0] && m_pv[1]) begin
                g = int'(m_rr);
                m_rr = ~m_rr;
            end else if (m_pv[0]) g = 0;
            else if (m_pv[1]) g = 1;
        end
        if (rdy && m_q.size() > 0) void'(m_q.pop_front());
        if (g >= 0) begin
            m_q.push_back(m_pe[g]);
            m_pv[g] = 1'b0;
        end
        for (int p = 0; p < 2; p++) begin
            cd = code_of(m_s[p]);
            ev = 1'b0;
            rep = 1'b0;
            if (cd == 4'd0) begin
                m_held[p] = 4'd0;
            end else if (cd != m_held[p]) begin
                ev = 1'b1;
                m_held[p] = cd;
                m_next[p] = cyc + D;
            end else if (cd >= 4'd5 && cd <= 4'd8 && cyc == m_next[p]) begin
                ev = 1'b1;
                rep = 1'b1;
                m_next[p] = cyc + R;
            end
            if (ev) begin
                if (m_pv[p]) m_ovf = 1'b1;
                else begin
                    m_pv[p] = 1'b1;
                    m_pe[p] = {1'(p), cd, rep};
                end
            end
        end
        m_s[0] = a;
        m_s[1] = b;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("valid", 16'(evt_valid), 16'(m_q.size() != 0));
        chk("head", 16'({evt_player, evt_code, evt_repeat}), 16'((m_q.size() != 0) ? m_q[0] : 6'd0));
        chk("count", 16'(evt_count), 16'(m_q.size()));
        chk("overflow", 16'(overflow), 16'(m_ovf));
    endtask

    task automatic step();
        if (evt_valid && evt_ready) pop_log.push_back({evt_player, evt_code, evt_repeat});
        @(posedge clock);
        model_edge(c1, c2, evt_ready);
        #1;
        check_model();
    endtask

    task automatic hold(input logic [9:0] a, input logic [9:0] b, input int n);
        c1 = a;
        c2 = b;
        repeat (n) step();
    endtask

    task automatic chk_log(input string tag, input logic [5:0] exp [$]);
        chk({tag, "_n"}, 16'(pop_log.size()), 16'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            chk(tag, 16'((i < pop_log.size()) ? pop_log[i] : 6'h3f), 16'(exp[i]));
    endtask

    initial begin
        int reps;
        model_reset();
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_valid", 16'(evt_valid), 16'd0);
        chk("rst_count", 16'(evt_count), 16'd0);
        chk("rst_ovf", 16'(overflow), 16'd0);
        chk("rst_code", 16'(evt_code), 16'd0);
        reset = 1'b1;

        // Single non-repeating press; latency of three edges.
        c1 = 10'h002;
        step(); step();
        chk("t1_lat2", 16'(evt_valid), 16'd0);
        step();
        chk("t1_lat3", 16'(evt_valid), 16'd1);
        chk("t1_head", 16'({evt_player, evt_code, evt_repeat}), 16'({1'b0, 4'd2, 1'b0}));
        hold(10'h002, 10'h000, 7);
        hold(10'h000, 10'h000, 4);
        chk("t1_one", 16'(evt_count), 16'd1);
        evt_ready = 1'b1;
        hold(10'h000, 10'h000, 3);

        // Auto-repeat on a D-pad button.
        pop_log.delete();
        hold(10'h010, 10'h000, 40);
        hold(10'h000, 10'h000, 5);
        reps = 0;
        foreach (pop_log[i]) if (pop_log[i][0]) reps++;
        chk("t2_total", 16'(pop_log.size()), 16'd7);
        chk("t2_reps", 16'(reps), 16'd6);
        chk("t2_first", 16'((pop_log.size() > 0) ? pop_log[0] : 6'h3f), 16'({1'b0, 4'd5, 1'b0}));

        // START held long: single event, no repeat.
        pop_log.delete();
        hold(10'h000, 10'h200, 100);
        hold(10'h000, 10'h000, 4);
        chk_log("t3", '{{1'b1, 4'd10, 1'b0}});

        // Simultaneous presses: round-robin order flips on the second pair.
        pop_log.delete();
        evt_ready = 1'b0;
        hold(10'h001, 10'h008, 6);
        evt_ready = 1'b1;
        hold(10'h000, 10'h000, 4);
        evt_ready = 1'b0;
        hold(10'h004, 10'h040, 6);
        evt_ready = 1'b1;
        hold(10'h000, 10'h000, 4);
        chk_log("t4", '{{1'b0, 4'd1, 1'b0}, {1'b1, 4'd4, 1'b0},
                        {1'b1, 4'd7, 1'b0}, {1'b0, 4'd3, 1'b0}});

        // Full FIFO, one pending, one dropped.
        evt_ready = 1'b0;
        hold(10'h001, 10'h000, 5);
        hold(10'h002, 10'h000, 5);
        hold(10'h004, 10'h000, 5);
        hold(10'h008, 10'h000, 5);
        hold(10'h020, 10'h000, 5);
        hold(10'h080, 10'h000, 5);
        hold(10'h000, 10'h000, 5);
        chk("t5_count", 16'(evt_count), 16'd4);
        chk("t5_ovf", 16'(overflow), 16'd1);
        pop_log.delete();
        evt_ready = 1'b1;
        hold(10'h000, 10'h000, 8);
        chk_log("t5", '{{1'b0, 4'd1, 1'b0}, {1'b0, 4'd2, 1'b0}, {1'b0, 4'd3, 1'b0},
                        {1'b0, 4'd4, 1'b0}, {1'b0, 4'd6, 1'b0}});

        // Reset mid-repeat with three queued, button held through reset.
        evt_ready = 1'b0;
        hold(10'h020, 10'h000, 24);
        chk("t6_pre", 16'(evt_count), 16'd3);
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", 16'(evt_valid), 16'd0);
        chk("t6_count", 16'(evt_count), 16'd0);
        chk("t6_ovf", 16'(overflow), 16'd0);
        model_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        hold(10'h020, 10'h000, 5);
        chk("t6_fresh", 16'(evt_count), 16'd1);
        chk("t6_head", 16'({evt_player, evt_code, evt_repeat}), 16'({1'b0, 4'd6, 1'b0}));
        evt_ready = 1'b1;
        hold(10'h000, 10'h000, 4);

        // Random activity on both pads with a random consumer.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) c1 = rand_vec();
            if ($urandom_range(0, 11) == 0) c2 = rand_vec();
            evt_ready = ($urandom_range(0, 9) < 7);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
